// File: rtl/drum_timing_gen.sv
// Master drum timing generator: bit-time / word-time counters and strobes
// phase-locked to the long-line revolution, plus post-reset flush gating.
// Optional macro G15_TIMING_CHECK_EN adds CN timing-track readback compare.
module drum_timing_gen #(
   parameter int BITS_PER_WORD = 29,
   parameter int WORDS_PER_REV = 108,
   parameter int FLUSH_REVS    = 1
) (
   input  logic       CLOCK,
   input  logic       RESET,
`ifdef G15_TIMING_CHECK_EN
   input  logic       CN_TRACK,
   output logic       TIMING_ERR,
`endif
   output logic       T0,
   output logic       T1,
   output logic       T28,
   output logic [4:0] TBIT,
   output logic [6:0] WORD,
   output logic       WORD_ODD,
   output logic       REV_START,
   output logic       DRUM_READY
);

   localparam logic [4:0] TB_MAX = 5'(BITS_PER_WORD - 1);
   localparam logic [6:0] WD_MAX = 7'(WORDS_PER_REV - 1);
   localparam int         FCW    = (FLUSH_REVS < 1) ? 1 : $clog2(FLUSH_REVS + 1);

   typedef enum logic {FLUSH, RUN} state_t;

   logic [4:0]     tbit;
   logic [6:0]     word;
   logic           tbit_wrap, word_wrap, rev_end;
   state_t         state, state_nxt;
   logic [FCW-1:0] fcnt, fcnt_nxt;
   logic [FCW:0]   fcnt_inc;

   // Out-of-range (upset) values are treated as the wrap point.
   assign tbit_wrap = (tbit >= TB_MAX);
   assign word_wrap = (word >= WD_MAX);
   // Last bit of the revolution: the next edge lands on REV_START.
   assign rev_end   = tbit_wrap & word_wrap;
   assign fcnt_inc  = {1'b0, fcnt} + (FCW+1)'(1);

   // Free-running bit and word counters.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         tbit <= '0;
         word <= '0;
      end else begin
         tbit <= tbit_wrap ? 5'd0 : tbit + 5'd1;
         if (tbit_wrap) word <= word_wrap ? 7'd0 : word + 7'd1;
      end
   end

   // Flush FSM state and revolution count register.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state <= FLUSH;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // Count completed revolutions; the transition is taken on the edge that
   // enters the next REV_START so DRUM_READY rises together with it.
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      case (state)
         FLUSH: begin
            if (FLUSH_REVS == 0) begin
               state_nxt = RUN;
            end else if (rev_end) begin
               fcnt_nxt = fcnt_inc[FCW-1:0];
               if (fcnt_inc == (FCW+1)'(FLUSH_REVS)) state_nxt = RUN;
            end
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = FLUSH;
      endcase
   end

   // FSM output and zero-latency strobe decodes.
   always_comb begin
      DRUM_READY = (state == RUN);
      TBIT       = tbit;
      WORD       = word;
      T0         = (tbit == 5'd0);
      T1         = (tbit == 5'd1);
      T28        = (tbit == 5'd28);
      WORD_ODD   = word[0];
      REV_START  = (tbit == 5'd0) && (word == 7'd0);
   end

`ifdef G15_TIMING_CHECK_EN
   logic [6:0] cn_sr;
   logic       err_q;
   logic       cmp_fail;

   // Compare the word number assembled from T0..T6 against WORD at T7.
   assign cmp_fail   = (tbit == 5'd7) && DRUM_READY && (cn_sr != word);
   assign TIMING_ERR = err_q | cmp_fail;

   // CN track is LSB first, so shift right; error flag is sticky to RESET.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         cn_sr <= '0;
         err_q <= 1'b0;
      end else begin
         if (tbit <= 5'd6) cn_sr <= {CN_TRACK, cn_sr[6:1]};
         if (cmp_fail)     err_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_drum_timing_gen.sv
// Directed bench for drum_timing_gen: vector table over a long run, then
// mid-operation reset, FLUSH_REVS=0 instance, and optional CN compare.
module tb_drum_timing_gen;

   typedef struct {
      int         cyc;
      logic [4:0] tbit;
      logic [6:0] word;
      logic       t0, t1, t28, odd, rev, rdy;
   } vec_t;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic       T0, T1, T28, WORD_ODD, REV_START, DRUM_READY;
   logic [4:0] TBIT;
   logic [6:0] WORD;
   logic       z_T0, z_T1, z_T28, z_WORD_ODD, z_REV_START, z_DRUM_READY;
   logic [4:0] z_TBIT;
   logic [6:0] z_WORD;
`ifdef G15_TIMING_CHECK_EN
   logic       CN_TRACK = 1'b0;
   logic       TIMING_ERR;
   logic       z_CN_TRACK = 1'b0;
   logic       z_TIMING_ERR;
`endif

   int pass_cnt = 0;
   int total    = 0;
   int cyc      = 0;
   int m_tbit   = 0;
   int m_word   = 0;
   bit corrupt_flush = 0;
   bit corrupt_cw    = 0;

   always #5 CLOCK = ~CLOCK;

   drum_timing_gen #(.FLUSH_REVS(1)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
`ifdef G15_TIMING_CHECK_EN
      .CN_TRACK(CN_TRACK), .TIMING_ERR(TIMING_ERR),
`endif
      .T0(T0), .T1(T1), .T28(T28), .TBIT(TBIT), .WORD(WORD),
      .WORD_ODD(WORD_ODD), .REV_START(REV_START), .DRUM_READY(DRUM_READY));

   drum_timing_gen #(.FLUSH_REVS(0)) dut0 (
      .CLOCK(CLOCK), .RESET(RESET),
`ifdef G15_TIMING_CHECK_EN
      .CN_TRACK(z_CN_TRACK), .TIMING_ERR(z_TIMING_ERR),
`endif
      .T0(z_T0), .T1(z_T1), .T28(z_T28), .TBIT(z_TBIT), .WORD(z_WORD),
      .WORD_ODD(z_WORD_ODD), .REV_START(z_REV_START), .DRUM_READY(z_DRUM_READY));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
   endtask

   // CN track bit for the current cycle, sampled at the coming edge.
   task automatic drive_cn();
`ifdef G15_TIMING_CHECK_EN
      logic [6:0] w;
      w = 7'(m_word);
      if (corrupt_flush && cyc < 3132) w = ~w;
      if (corrupt_cw && m_word == 37)  w = 7'd38;
      CN_TRACK = (m_tbit < 7) ? w[m_tbit] : 1'b0;
`endif
   endtask

   task automatic next_cycle();
      @(negedge CLOCK);
      cyc++;
      if (m_tbit == 28) begin
         m_tbit = 0;
         m_word = (m_word == 107) ? 0 : m_word + 1;
      end else begin
         m_tbit++;
      end
      drive_cn();
   endtask

   // Reset is taken at the next posedge; returns sampling cycle 0.
   task automatic apply_reset();
      RESET = 1'b1;
      @(negedge CLOCK);
      RESET  = 1'b0;
      cyc    = 0;
      m_tbit = 0;
      m_word = 0;
      drive_cn();
   endtask

   vec_t tbl[13];

   initial begin
      int idx, bad_rev, bad_rdy, err_bad, guard;
      tbl[0]  = '{0,     5'd0,  7'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1,     5'd1,  7'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{2,     5'd2,  7'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{9,     5'd9,  7'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{28,    5'd28, 7'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{29,    5'd0,  7'd1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{57,    5'd28, 7'd1,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{58,    5'd0,  7'd2,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{3131,  5'd28, 7'd107, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{3132,  5'd0,  7'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{3133,  5'd1,  7'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{5000,  5'd12, 7'd64,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{10000, 5'd24, 7'd20,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      // Long run from reset against the vector table.
      apply_reset();
      idx = 0; bad_rev = 0; bad_rdy = 0;
      while (cyc <= 10000) begin
         if (idx < 13 && cyc == tbl[idx].cyc) begin
            chk($sformatf("tbit@%0d", cyc), 32'(TBIT),      32'(tbl[idx].tbit));
            chk($sformatf("word@%0d", cyc), 32'(WORD),      32'(tbl[idx].word));
            chk($sformatf("t0@%0d",   cyc), 32'(T0),        32'(tbl[idx].t0));
            chk($sformatf("t1@%0d",   cyc), 32'(T1),        32'(tbl[idx].t1));
            chk($sformatf("t28@%0d",  cyc), 32'(T28),       32'(tbl[idx].t28));
            chk($sformatf("odd@%0d",  cyc), 32'(WORD_ODD),  32'(tbl[idx].odd));
            chk($sformatf("rev@%0d",  cyc), 32'(REV_START), 32'(tbl[idx].rev));
            chk($sformatf("rdy@%0d",  cyc), 32'(DRUM_READY),32'(tbl[idx].rdy));
            idx++;
         end
         if (cyc == 0) chk("flush0_rdy@0", 32'(z_DRUM_READY), 32'd0);
         if (cyc == 1) chk("flush0_rdy@1", 32'(z_DRUM_READY), 32'd1);
         if (REV_START && cyc < 6264 && cyc != 0 && cyc != 3132) bad_rev++;
         if (cyc >= 3132 && !DRUM_READY) bad_rdy++;
         next_cycle();
      end
      chk("vectors_hit", 32'(idx), 32'd13);
      chk("stray_rev_start", 32'(bad_rev), 32'd0);
      chk("ready_dropped", 32'(bad_rdy), 32'd0);

      // Mid-operation reset at cycle 5000 (WORD=64, TBIT=12).
      apply_reset();
      while (cyc < 5000) next_cycle();
      chk("pre_rst_tbit", 32'(TBIT), 32'd12);
      chk("pre_rst_word", 32'(WORD), 32'd64);
      chk("pre_rst_rdy",  32'(DRUM_READY), 32'd1);
      apply_reset();
      chk("post_rst_tbit", 32'(TBIT), 32'd0);
      chk("post_rst_word", 32'(WORD), 32'd0);
      chk("post_rst_rdy",  32'(DRUM_READY), 32'd0);
      chk("post_rst_rev",  32'(REV_START), 32'd1);
      chk("post_rst_rdy0", 32'(z_DRUM_READY), 32'd0);
      next_cycle();
      chk("post_rst_rdy0_c1", 32'(z_DRUM_READY), 32'd1);
      while (cyc < 3131) next_cycle();
      chk("reflush_rdy@3131", 32'(DRUM_READY), 32'd0);
      next_cycle();
      chk("reflush_rdy@3132", 32'(DRUM_READY), 32'd1);

`ifdef G15_TIMING_CHECK_EN
      // Garbage during flush must be ignored; correct track for 2 revs after.
      corrupt_flush = 1;
      apply_reset();
      err_bad = 0;
      while (cyc < 9396) begin
         if (TIMING_ERR) err_bad++;
         next_cycle();
      end
      chk("cn_clean_err", 32'(err_bad), 32'd0);
      corrupt_cw = 1;
      guard = 0;
      while (!(m_word == 37 && m_tbit == 6) && guard < 4000) begin
         next_cycle();
         guard++;
      end
      chk("cn_reach_w37", 32'(guard < 4000), 32'd1);
      chk("cn_err_t6", 32'(TIMING_ERR), 32'd0);
      next_cycle();
      chk("cn_err_t7", 32'(TIMING_ERR), 32'd1);
      corrupt_cw = 0;
      err_bad = 0;
      repeat (500) begin
         next_cycle();
         if (!TIMING_ERR) err_bad++;
      end
      chk("cn_err_sticky", 32'(err_bad), 32'd0);
      apply_reset();
      chk("cn_err_rst", 32'(TIMING_ERR), 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
